wb_commit_tracer: RTL and testbench
===================================

Name: wb_commit_tracer

Overview:
Sits on the writeback-stage outputs of the processing unit and consumes the retire stream: opcode, funct3, rd address, rd data and next PC. Each retiring instruction is captured as a commit record and buffered in a small FIFO. Records are drained to a trace/debug consumer over a valid/ready handshake. The block also keeps a retire counter, a drop counter and a sticky overflow flag for self-checking benches and debug.

Parameters:
DWIDTH, 32, rd data width
AWIDTH, 5, rd address width
FUNCT_WIDTH, 3, funct3 width
OPCODE_WIDTH, 7, opcode width (same value as the shared opcode-width define)
PC_WIDTH, 32, next-PC width
FIFO_DEPTH, 8, record entries; power of two, >= 2
CNT_WIDTH, 32, retire/drop counter width

Ports:
t_clk  in  1  clock, rising edge
t_rst  in  1  reset; asynchronous, active-low
t_i_ce  in  1  writeback stage presents a retiring instruction this cycle
t_i_ws_stall  in  1  writeback stall (from processing unit)
t_i_ws_flush  in  1  writeback flush (from processing unit)
t_i_ws_opcode  in  OPCODE_WIDTH  retiring opcode
t_i_ws_funct3  in  FUNCT_WIDTH  retiring funct3
t_i_ws_addr_rd  in  AWIDTH  rd address
t_i_ws_data_rd  in  DWIDTH  rd write data
t_i_ws_next_pc  in  PC_WIDTH  next PC
t_i_ready  in  1  consumer accepts the head record
t_i_clr  in  1  synchronous clear of counters and overflow flag
t_o_valid  out  1  head record available
t_o_opcode / t_o_funct3 / t_o_addr_rd / t_o_data_rd / t_o_next_pc  out  field widths  head record fields
t_o_level  out  clog2(FIFO_DEPTH)+1  current occupancy
t_o_retire_cnt  out  CNT_WIDTH  captured retires
t_o_drop_cnt  out  CNT_WIDTH  records lost to a full FIFO
t_o_overflow  out  1  sticky; at least one drop since reset/clear

Behaviour:
- Reset (t_rst=0, async): FIFO empty, all pointers 0, t_o_valid=0, all t_o_* fields 0, level=0, both counters 0, overflow=0.
- Capture condition: capture = t_i_ce & ~t_i_ws_stall & ~t_i_ws_flush. Flush has priority; stall and flush together produce no capture.
- rd=x0 records are still captured; no filtering.
- Push on capture when not full, or when full with a pop in the same cycle. Full with a simultaneous pop: the pop frees the slot and the push is accepted, so level is unchanged.
- Drop: capture while full with no pop. The record is discarded, t_o_drop_cnt increments (saturates at all-ones), and overflow is set.
- t_o_retire_cnt increments on every capture, including drops. It wraps modulo 2^CNT_WIDTH.
- Pop = t_o_valid & t_i_ready. Ready while empty has no effect.
- Output is first-word-fall-through and registered. A record captured at edge N appears on t_o_valid/fields after edge N, with 1-cycle latency, even when the FIFO was empty.
- Head fields hold stable while t_o_valid=1 and t_i_ready=0. Fields are don't-care (hold last value) when t_o_valid=0.
- Push while empty with a simultaneous pop: no pop occurs (valid was 0). The record becomes the head.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty are derived from the level counter.
- t_i_clr: the next edge zeroes both counters and overflow. FIFO contents are untouched. A capture in the same cycle as t_i_clr makes retire_cnt=1 (or drop_cnt=1), i.e. clear-then-count.
- Reset asserted mid-operation empties the FIFO immediately. Queued records are lost, not drained.

Decomposition:
- Shared package/header: OPCODE_WIDTH define (reuse the existing one) and RISC-V opcode constants used by benches for decode checks.
- Record layout is concatenated {opcode, funct3, addr_rd, data_rd, next_pc}, total 79 bits at defaults; its width is a localparam.
- One sub-module: wb_record_fifo. It is a generic synchronous FWFT FIFO (WIDTH, DEPTH; push/pop/full/empty/level). The top level holds capture logic, counters and the overflow flag.

Test Plan:
- Reset: t_rst=0 for 2 cycles, then release -> valid=0, level=0, retire_cnt=0, drop_cnt=0, overflow=0.
- Single capture: ce=1 for one cycle with opcode=0110011, funct3=000, rd=5, data=42, next_pc=8, ready=0 -> next cycle valid=1 with those fields, level=1, retire_cnt=1; then ready=1 -> valid=0 after the edge.
- Stall/flush gating: ce=1 with stall=1 for 3 cycles, then flush=1 for 2 cycles -> no captures, retire_cnt=0, level=0.
- Fill and overflow: ready=0, 10 consecutive captures with data=1..10 -> level=8, retire_cnt=10, drop_cnt=2, overflow=1; drain yields data 1..8 in order.
- Full with simultaneous push/pop: at level=8 apply ce=1 and ready=1 for 4 cycles -> level stays 8, drop_cnt unchanged, output order is preserved.
- Clear and mid-run reset: pulse t_i_clr together with a capture -> retire_cnt=1, drop_cnt=0, overflow=0; then assert t_rst while level=3 -> valid and level drop to 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/wb_commit_tracer_pkg.sv
// Shared widths, RISC-V opcode constants and record-width helper for the
// writeback commit tracer.
package wb_commit_tracer_pkg;

  // Shared opcode width used across the processing unit and the tracer
  localparam int WB_OPCODE_WIDTH = 7;

  // RISC-V base opcodes, handy when benches decode traced records
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_OP     = 7'b0110011;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [WB_OPCODE_WIDTH-1:0] OPC_SYSTEM = 7'b1110011;

  // Width of one commit record {opcode, funct3, rd, rd data, next pc}
  function automatic int recordWidth(input int opW, input int f3W, input int aW,
                                     input int dW, input int pcW);
    return opW + f3W + aW + dW + pcW;
  endfunction

  // Record width at default parameters (79 bits)
  localparam int WB_RECORD_WIDTH_DEF = recordWidth(WB_OPCODE_WIDTH, 3, 5, 32, 32);

endpackage

// File: rtl/wb_commit_tracer_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head.
// A word pushed into an empty FIFO shows up on data_o right after the edge.
module wb_record_fifo #(
  parameter int WIDTH = 79,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full, empty, doPush, doPop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign doPop   = pop_i & ~empty;
  assign doPush  = push_i & (~full | doPop);

  assign data_o  = head_q;
  assign valid_o = ~empty;
  assign full_o  = full;
  assign empty_o = empty;
  assign level_o = level_q;

  // Next pointers, level and head; the head comes straight from the incoming
  // word when that word lands in the slot that becomes the new head
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = head_q;
    if (doPush) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (doPop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({doPush, doPop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (level_d != '0) begin
      if (doPush && (wr_ptr_q == rd_ptr_d)) head_d = data_i;
      else                                  head_d = mem_q[rd_ptr_d];
    end
  end

  // Storage array; contents need no reset because level gates visibility
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer, level and head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/wb_commit_tracer.sv
// Writeback commit tracer: captures each retiring instruction as a record,
// buffers it, and keeps retire/drop counters plus a sticky overflow flag.
module wb_commit_tracer
  import wb_commit_tracer_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int FUNCT_WIDTH  = 3,
  parameter int OPCODE_WIDTH = WB_OPCODE_WIDTH,
  parameter int PC_WIDTH     = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                         t_clk,
  input  logic                         t_rst,
  input  logic                         t_i_ce,
  input  logic                         t_i_ws_stall,
  input  logic                         t_i_ws_flush,
  input  logic [OPCODE_WIDTH-1:0]      t_i_ws_opcode,
  input  logic [FUNCT_WIDTH-1:0]       t_i_ws_funct3,
  input  logic [AWIDTH-1:0]            t_i_ws_addr_rd,
  input  logic [DWIDTH-1:0]            t_i_ws_data_rd,
  input  logic [PC_WIDTH-1:0]          t_i_ws_next_pc,
  input  logic                         t_i_ready,
  input  logic                         t_i_clr,
  output logic                         t_o_valid,
  output logic [OPCODE_WIDTH-1:0]      t_o_opcode,
  output logic [FUNCT_WIDTH-1:0]       t_o_funct3,
  output logic [AWIDTH-1:0]            t_o_addr_rd,
  output logic [DWIDTH-1:0]            t_o_data_rd,
  output logic [PC_WIDTH-1:0]          t_o_next_pc,
  output logic [$clog2(FIFO_DEPTH):0]  t_o_level,
  output logic [CNT_WIDTH-1:0]         t_o_retire_cnt,
  output logic [CNT_WIDTH-1:0]         t_o_drop_cnt,
  output logic                         t_o_overflow
);

  localparam int REC_W = recordWidth(OPCODE_WIDTH, FUNCT_WIDTH, AWIDTH, DWIDTH, PC_WIDTH);

  logic             capture, pop, push, drop, fifoFull, fifoEmpty;
  logic [REC_W-1:0] recIn, recOut;
  logic [CNT_WIDTH-1:0] retireCnt_q, retireCnt_d;
  logic [CNT_WIDTH-1:0] dropCnt_q, dropCnt_d;
  logic                 overflow_q, overflow_d;

  // Flush wins over everything; a stalled instruction has not retired yet
  assign capture = t_i_ce & ~t_i_ws_stall & ~t_i_ws_flush;
  assign pop     = t_o_valid & t_i_ready;
  assign push    = capture & (~fifoFull | pop);
  assign drop    = capture & fifoFull & ~pop;

  assign recIn = {t_i_ws_opcode, t_i_ws_funct3, t_i_ws_addr_rd, t_i_ws_data_rd, t_i_ws_next_pc};
  assign {t_o_opcode, t_o_funct3, t_o_addr_rd, t_o_data_rd, t_o_next_pc} = recOut;

  wb_record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk     (t_clk),
    .rst_n   (t_rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (recIn),
    .data_o  (recOut),
    .valid_o (t_o_valid),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (t_o_level)
  );

  // Clear first, then count whatever happens this cycle; drop count saturates
  always_comb begin
    retireCnt_d = t_i_clr ? '0 : retireCnt_q;
    dropCnt_d   = t_i_clr ? '0 : dropCnt_q;
    overflow_d  = t_i_clr ? 1'b0 : overflow_q;
    if (capture) retireCnt_d = retireCnt_d + CNT_WIDTH'(1);
    if (drop) begin
      if (dropCnt_d != '1) dropCnt_d = dropCnt_d + CNT_WIDTH'(1);
      overflow_d = 1'b1;
    end
  end

  // Counter and sticky flag registers
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      retireCnt_q <= '0;
      dropCnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      retireCnt_q <= retireCnt_d;
      dropCnt_q   <= dropCnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign t_o_retire_cnt = retireCnt_q;
  assign t_o_drop_cnt   = dropCnt_q;
  assign t_o_overflow   = overflow_q;

endmodule

// File: tb/tb_wb_commit_tracer.sv
// Directed bench for wb_commit_tracer with hand-computed expectations.
module tb_wb_commit_tracer;
  import wb_commit_tracer_pkg::*;

  logic        t_clk = 1'b0;
  logic        t_rst;
  logic        t_i_ce, t_i_ws_stall, t_i_ws_flush, t_i_ready, t_i_clr;
  logic [6:0]  t_i_ws_opcode;
  logic [2:0]  t_i_ws_funct3;
  logic [4:0]  t_i_ws_addr_rd;
  logic [31:0] t_i_ws_data_rd;
  logic [31:0] t_i_ws_next_pc;
  logic        t_o_valid;
  logic [6:0]  t_o_opcode;
  logic [2:0]  t_o_funct3;
  logic [4:0]  t_o_addr_rd;
  logic [31:0] t_o_data_rd;
  logic [31:0] t_o_next_pc;
  logic [3:0]  t_o_level;
  logic [31:0] t_o_retire_cnt;
  logic [31:0] t_o_drop_cnt;
  logic        t_o_overflow;

  int total = 0;
  int bad   = 0;

  wb_commit_tracer dut (
    .t_clk          (t_clk),
    .t_rst          (t_rst),
    .t_i_ce         (t_i_ce),
    .t_i_ws_stall   (t_i_ws_stall),
    .t_i_ws_flush   (t_i_ws_flush),
    .t_i_ws_opcode  (t_i_ws_opcode),
    .t_i_ws_funct3  (t_i_ws_funct3),
    .t_i_ws_addr_rd (t_i_ws_addr_rd),
    .t_i_ws_data_rd (t_i_ws_data_rd),
    .t_i_ws_next_pc (t_i_ws_next_pc),
    .t_i_ready      (t_i_ready),
    .t_i_clr        (t_i_clr),
    .t_o_valid      (t_o_valid),
    .t_o_opcode     (t_o_opcode),
    .t_o_funct3     (t_o_funct3),
    .t_o_addr_rd    (t_o_addr_rd),
    .t_o_data_rd    (t_o_data_rd),
    .t_o_next_pc    (t_o_next_pc),
    .t_o_level      (t_o_level),
    .t_o_retire_cnt (t_o_retire_cnt),
    .t_o_drop_cnt   (t_o_drop_cnt),
    .t_o_overflow   (t_o_overflow)
  );

  // Free-running 10 ns clock
  always #5 t_clk = ~t_clk;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one writeback beat; fields other than data are fixed per beat
  task automatic applyStimulus(input logic ce, input logic [31:0] data, input logic ready);
    t_i_ce         = ce;
    t_i_ws_opcode  = OPC_OP_IMM;
    t_i_ws_funct3  = 3'b001;
    t_i_ws_addr_rd = 5'd0;
    t_i_ws_data_rd = data;
    t_i_ws_next_pc = data << 2;
    t_i_ready      = ready;
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  initial begin
    int expQ [$];
    t_rst = 1'b0;
    t_i_ws_stall = 1'b0;
    t_i_ws_flush = 1'b0;
    t_i_clr = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0);

    // Reset held for two cycles
    tick();
    tick();
    t_rst = 1'b1;
    #1;
    checkOutput("rst_valid",  t_o_valid, 0);
    checkOutput("rst_level",  t_o_level, 0);
    checkOutput("rst_retire", t_o_retire_cnt, 0);
    checkOutput("rst_drop",   t_o_drop_cnt, 0);
    checkOutput("rst_ovf",    t_o_overflow, 0);
    checkOutput("rst_data",   t_o_data_rd, 0);

    // Single capture with explicit fields
    t_i_ce = 1'b1;
    t_i_ws_opcode = 7'b0110011;
    t_i_ws_funct3 = 3'b000;
    t_i_ws_addr_rd = 5'd5;
    t_i_ws_data_rd = 32'd42;
    t_i_ws_next_pc = 32'd8;
    t_i_ready = 1'b0;
    tick();
    t_i_ce = 1'b0;
    checkOutput("one_valid",  t_o_valid, 1);
    checkOutput("one_opc",    t_o_opcode, 7'b0110011);
    checkOutput("one_f3",     t_o_funct3, 0);
    checkOutput("one_rd",     t_o_addr_rd, 5);
    checkOutput("one_data",   t_o_data_rd, 42);
    checkOutput("one_pc",     t_o_next_pc, 8);
    checkOutput("one_level",  t_o_level, 1);
    checkOutput("one_retire", t_o_retire_cnt, 1);
    tick();
    checkOutput("hold_data",  t_o_data_rd, 42);
    checkOutput("hold_valid", t_o_valid, 1);
    t_i_ready = 1'b1;
    tick();
    checkOutput("pop_valid",  t_o_valid, 0);
    checkOutput("pop_level",  t_o_level, 0);
    tick();
    checkOutput("rdy_empty_level", t_o_level, 0);

    // Stall, flush and both together never capture
    applyStimulus(1'b1, 32'd500, 1'b0);
    t_i_ws_stall = 1'b1;
    repeat (3) tick();
    t_i_ws_stall = 1'b0;
    t_i_ws_flush = 1'b1;
    repeat (2) tick();
    t_i_ws_stall = 1'b1;
    tick();
    t_i_ws_stall = 1'b0;
    t_i_ws_flush = 1'b0;
    t_i_ce = 1'b0;
    checkOutput("gate_retire", t_o_retire_cnt, 1);
    checkOutput("gate_level",  t_o_level, 0);
    checkOutput("gate_valid",  t_o_valid, 0);

    // Push into empty FIFO with ready high: no pop, record becomes head
    applyStimulus(1'b1, 32'd77, 1'b1);
    tick();
    checkOutput("pe_valid", t_o_valid, 1);
    checkOutput("pe_data",  t_o_data_rd, 77);
    checkOutput("pe_pc",    t_o_next_pc, 77 * 4);
    checkOutput("pe_opc",   t_o_opcode, OPC_OP_IMM);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    checkOutput("pe_drain", t_o_valid, 0);

    // Fill with ten captures, two are dropped
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      tick();
    end
    checkOutput("fill_level",  t_o_level, 8);
    checkOutput("fill_retire", t_o_retire_cnt, 12);
    checkOutput("fill_drop",   t_o_drop_cnt, 2);
    checkOutput("fill_ovf",    t_o_overflow, 1);
    checkOutput("fill_head",   t_o_data_rd, 1);

    // Full with simultaneous push and pop keeps level and order
    for (int i = 1; i <= 8; i++) expQ.push_back(i);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(11 + i), 1'b1);
      expQ.push_back(11 + i);
      void'(expQ.pop_front());
      tick();
      checkOutput("fpp_level", t_o_level, 8);
      checkOutput("fpp_head",  t_o_data_rd, expQ[0]);
    end
    checkOutput("fpp_drop",   t_o_drop_cnt, 2);
    checkOutput("fpp_retire", t_o_retire_cnt, 16);

    // Drain and compare order: 5..8 then 11..14
    applyStimulus(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_valid", t_o_valid, 1);
      checkOutput("drain_data",  t_o_data_rd, expQ[i]);
      tick();
    end
    checkOutput("drain_empty", t_o_valid, 0);
    checkOutput("drain_ovf",   t_o_overflow, 1);

    // Clear together with a capture counts the capture after clearing
    applyStimulus(1'b1, 32'd99, 1'b0);
    t_i_clr = 1'b1;
    tick();
    t_i_clr = 1'b0;
    checkOutput("clr_retire", t_o_retire_cnt, 1);
    checkOutput("clr_drop",   t_o_drop_cnt, 0);
    checkOutput("clr_ovf",    t_o_overflow, 0);
    checkOutput("clr_level",  t_o_level, 1);
    applyStimulus(1'b1, 32'd100, 1'b0);
    tick();
    applyStimulus(1'b1, 32'd101, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("pre_rst_level", t_o_level, 3);
    checkOutput("pre_rst_head",  t_o_data_rd, 99);

    // Mid-run reset empties immediately, between clock edges
    t_rst = 1'b0;
    #1;
    checkOutput("mrst_valid",  t_o_valid, 0);
    checkOutput("mrst_level",  t_o_level, 0);
    checkOutput("mrst_retire", t_o_retire_cnt, 0);
    tick();
    t_rst = 1'b1;
    #1;
    checkOutput("post_rst_valid", t_o_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
